rect_geom_seq: RTL and testbench

RECT_GEOM_SEQ -- requirements
Module: rect_geom_seq

---
 rtl/rect_geom_seq_if.sv | 32 +++
 rtl/rect_geom_seq.sv | 113 +++++++++++
 tb/tb_rect_geom_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rect_geom_seq_if.sv
// Producer-side bundle for rect_geom_seq: active-low data-valid handshake,
// the operation select, both rectangle sides and the result register.
interface rect_geom_seq_if #(
  parameter int N = 4
);
  logic           _dav;
  logic           rfd;
  logic           mode;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [2*N-1:0] p;

  // Producer side: drives the request, observes readiness and the result.
  modport master (
    output _dav,
    output mode,
    output a,
    output b,
    input  rfd,
    input  p
  );

  // Geometry engine side.
  modport slave (
    input  _dav,
    input  mode,
    input  a,
    input  b,
    output rfd,
    output p
  );
endinterface

// File: rtl/rect_geom_seq.sv
// Rectangle geometry engine: perimeter 2*(A+B) in one compute cycle, or area
// A*B through a shift-add multiplier that consumes one multiplier bit per
// cycle for exactly N cycles. Operands are latched on capture so the producer
// may change its inputs freely while the operation runs.
module rect_geom_seq #(
  parameter int N = 4
) (
  input  logic          clock,
  input  logic          reset,
  rect_geom_seq_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S0 = 2'd0,   // idle, accepting
    S1 = 2'd1,   // compute
    S2 = 2'd2    // wait for _dav release
  } state_t;

  state_t         state_q;
  logic           rfd_q;
  logic           mode_q;
  logic [2*N-1:0] mcand_q;   // A, shifted left one place per area step
  logic [N-1:0]   mplier_q;  // B, shifted right one place per area step
  logic [2*N-1:0] acc_q;     // running partial product, never visible on p
  logic [CW-1:0]  cnt_q;     // remaining area steps
  logic [2*N-1:0] p_q;

  logic [2*N-1:0] acc_d;
  logic [2*N-1:0] mcand_d;
  logic [N-1:0]   mplier_d;
  logic [CW-1:0]  cnt_d;
  logic [2*N-1:0] perim_d;

  // Perimeter of the latched sides; the 2N-bit width cannot overflow for N >= 2.
  function automatic logic [2*N-1:0] f_perimeter(input logic [N-1:0] sa,
                                                  input logic [N-1:0] sb);
    logic [2*N-1:0] sum;
    sum = {{N{1'b0}}, sa} + {{N{1'b0}}, sb};
    return sum << 1;
  endfunction

  // One shift-add step plus the perimeter, both from the latched operands.
  always_comb begin
    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
    cnt_d    = cnt_q - CW'(1);
    perim_d  = f_perimeter(mcand_q[N-1:0], mplier_q);
  end

  // Control FSM with registered rfd/p and the operand datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S0;
      rfd_q    <= 1'b1;
      p_q      <= '0;
      mode_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S0: begin
          rfd_q <= 1'b1;
          if (!bus._dav) begin
            mode_q   <= bus.mode;
            mcand_q  <= {{N{1'b0}}, bus.a};
            mplier_q <= bus.b;
            acc_q    <= '0;
            cnt_q    <= CW'(N);
            rfd_q    <= 1'b0;
            state_q  <= S1;
          end
        end
        S1: begin
          rfd_q <= 1'b0;
          if (!mode_q) begin
            p_q     <= perim_d;
            state_q <= S2;
          end else begin
            // Zero operands still run all N steps; the count alone ends S1.
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            if (cnt_q == CW'(1)) begin
              p_q     <= acc_d;
              state_q <= S2;
            end
          end
        end
        S2: begin
          rfd_q <= 1'b0;
          if (bus._dav) begin
            rfd_q   <= 1'b1;
            state_q <= S0;
          end
        end
        default: begin
          rfd_q   <= 1'b1;
          state_q <= S0;
        end
      endcase
    end
  end

  assign bus.rfd = rfd_q;
  assign bus.p   = p_q;

endmodule

// File: tb/tb_rect_geom_seq.sv
// Bench for rect_geom_seq: directed scenarios and randomized transactions on
// an N=4 instance, plus an N=8 instance, against a behavioural model.
module tb_rect_geom_seq;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  // Model view of each instance's result register.
  logic [7:0]  p4_model;
  logic [15:0] p8_model;

  rect_geom_seq_if #(.N(4)) b4 ();
  rect_geom_seq_if #(.N(8)) b8 ();

  rect_geom_seq #(.N(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (b4)
  );

  rect_geom_seq #(.N(8)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (b8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete N=4 transaction. early raises _dav right after capture;
  // scramble changes a/b/mode right after capture.
  task automatic run4(input logic m, input logic [3:0] av, input logic [3:0] bv,
                      input bit early, input bit scramble, input string tag);
    int         exp_i;
    int         lat;
    logic [7:0] expv;
    exp_i = m ? int'(av) * int'(bv) : 2 * (int'(av) + int'(bv));
    expv  = 8'(exp_i);
    lat   = m ? 4 : 1;
    b4.a = av; b4.b = bv; b4.mode = m; b4._dav = 1'b0;
    tick();
    checks++;
    if (b4.rfd !== 1'b0) begin
      errors++; $display("FAIL %s capture_rfd: got %0b want 0", tag, b4.rfd);
    end
    if (scramble) begin
      b4.a = 4'($urandom); b4.b = 4'($urandom); b4.mode = ~m;
    end
    if (early) b4._dav = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (k == lat) p4_model = expv;
      checks++;
      if (b4.p !== p4_model || b4.rfd !== 1'b0) begin
        errors++;
        $display("FAIL %s step%0d: got p=%0d rfd=%0b want p=%0d rfd=0",
                 tag, k, b4.p, b4.rfd, p4_model);
      end
    end
    if (!early) begin
      tick();
      checks++;
      if (b4.rfd !== 1'b0 || b4.p !== p4_model) begin
        errors++;
        $display("FAIL %s hold_s2: got p=%0d rfd=%0b want p=%0d rfd=0",
                 tag, b4.p, b4.rfd, p4_model);
      end
      b4._dav = 1'b1;
    end
    tick();
    checks++;
    if (b4.rfd !== 1'b1 || b4.p !== p4_model) begin
      errors++;
      $display("FAIL %s release: got p=%0d rfd=%0b want p=%0d rfd=1",
               tag, b4.p, b4.rfd, p4_model);
    end
  endtask

  // One complete N=8 transaction, _dav released right after capture.
  task automatic run8(input logic m, input logic [7:0] av, input logic [7:0] bv,
                      input string tag);
    int          lat;
    logic [15:0] expv;
    expv = m ? 16'(int'(av) * int'(bv)) : 16'(2 * (int'(av) + int'(bv)));
    lat  = m ? 8 : 1;
    b8.a = av; b8.b = bv; b8.mode = m; b8._dav = 1'b0;
    tick();
    b8._dav = 1'b1;
    b8.a = 8'($urandom);
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (k == lat) p8_model = expv;
      checks++;
      if (b8.p !== p8_model || b8.rfd !== 1'b0) begin
        errors++;
        $display("FAIL %s step%0d: got p=%0d rfd=%0b want p=%0d rfd=0",
                 tag, k, b8.p, b8.rfd, p8_model);
      end
    end
    tick();
    checks++;
    if (b8.rfd !== 1'b1) begin
      errors++; $display("FAIL %s release: got rfd=%0b want 1", tag, b8.rfd);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    b4._dav = 1'b1; b4.a = '0; b4.b = '0; b4.mode = 1'b0;
    b8._dav = 1'b1; b8.a = '0; b8.b = '0; b8.mode = 1'b0;
    tick(); tick();
    p4_model = '0; p8_model = '0;
    checks++;
    if (b4.p !== 8'd0 || b4.rfd !== 1'b1 || b8.p !== 16'd0 || b8.rfd !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got p4=%0d rfd4=%0b p8=%0d rfd8=%0b want 0 1 0 1",
               b4.p, b4.rfd, b8.p, b8.rfd);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (b4.rfd !== 1'b1) begin
      errors++; $display("FAIL idle_rfd: got %0b want 1", b4.rfd);
    end
  endtask

  // _dav already low while reset is held: capture at the first free edge.
  task automatic test_reset_capture();
    reset = 1'b1;
    b4.a = 4'd2; b4.b = 4'd3; b4.mode = 1'b0; b4._dav = 1'b0;
    tick();
    p4_model = '0; p8_model = '0;
    checks++;
    if (b4.rfd !== 1'b1 || b4.p !== 8'd0) begin
      errors++;
      $display("FAIL rst_hold: got p=%0d rfd=%0b want p=0 rfd=1", b4.p, b4.rfd);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (b4.rfd !== 1'b0) begin
      errors++; $display("FAIL rst_release_capture: got rfd=%0b want 0", b4.rfd);
    end
    tick();
    p4_model = 8'd10;
    checks++;
    if (b4.p !== p4_model) begin
      errors++; $display("FAIL rst_release_result: got %0d want %0d", b4.p, p4_model);
    end
    b4._dav = 1'b1;
    tick();
    checks++;
    if (b4.rfd !== 1'b1) begin
      errors++; $display("FAIL rst_release_rfd: got %0b want 1", b4.rfd);
    end
  endtask

  task automatic test_directed();
    run4(1'b0, 4'd3,  4'd5,  1'b1, 1'b0, "perim_3x5");
    run4(1'b1, 4'd15, 4'd15, 1'b0, 1'b0, "area_15x15");
    run4(1'b0, 4'd15, 4'd15, 1'b0, 1'b0, "perim_15x15");
    run4(1'b1, 4'd0,  4'd9,  1'b0, 1'b0, "area_0x9");
    run4(1'b1, 4'd6,  4'd7,  1'b1, 1'b1, "area_6x7_scramble");
  endtask

  // Reset on the 2nd S1 edge of 9*9 after a previous p of 16.
  task automatic test_reset_abort();
    run4(1'b0, 4'd3, 4'd5, 1'b1, 1'b0, "abort_pre");
    b4.a = 4'd9; b4.b = 4'd9; b4.mode = 1'b1; b4._dav = 1'b0;
    tick();
    b4._dav = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    p4_model = '0; p8_model = '0;
    checks++;
    if (b4.p !== 8'd0 || b4.rfd !== 1'b1) begin
      errors++;
      $display("FAIL abort_reset: got p=%0d rfd=%0b want p=0 rfd=1", b4.p, b4.rfd);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (b4.p !== 8'd0 || b4.rfd !== 1'b1) begin
        errors++;
        $display("FAIL abort_after%0d: got p=%0d rfd=%0b want p=0 rfd=1",
                 k, b4.p, b4.rfd);
      end
    end
  endtask

  task automatic test_n8();
    run8(1'b1, 8'd255, 8'd255, "n8_area_255x255");
    run8(1'b0, 8'd255, 8'd255, "n8_perim_255x255");
    for (int i = 0; i < 4; i++)
      run8(1'($urandom), 8'($urandom), 8'($urandom), "n8_random");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      run4(1'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_back_to_back();
    run4(1'b1, 4'd13, 4'd11, 1'b1, 1'b0, "b2b_a");
    run4(1'b1, 4'd1,  4'd15, 1'b1, 1'b1, "b2b_b");
    run4(1'b0, 4'd0,  4'd0,  1'b1, 1'b0, "b2b_c");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reset_capture();
    test_directed();
    test_reset_abort();
    test_n8();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
